// File: rtl/opl3_slot_sequencer.sv
// opl3_slot_sequencer
//
// Per-sample operator-slot sequencer for the banked operator-state memory.
// A sample tick starts a frame. During the frame every (bank, operator) slot
// is read once. The operator index is the inner loop and the bank index is
// the outer loop. Each read is tagged so that the tag leaves the block aligned
// with the memory read data. The same tag is delayed again by the datapath
// latency to produce the write-back strobe and address.
//
// Parameters
//   NUM_BANKS   register banks (BANK_WIDTH = $clog2(NUM_BANKS))
//   NUM_OPS     operators per bank (OP_WIDTH = $clog2(NUM_OPS))
//   READ_DELAY  memory read latency, 0..2. Must match the memory OUTPUT_DELAY.
//   PROC_DELAY  cycles from rd_valid to write-back data, >= 1
//
// Ports
//   clk            system clock, rising edge
//   reset_n        synchronous active-low reset; flushes every pipeline
//   sample_clk_en  one-cycle frame start pulse; ignored while busy
//   reb            memory read enable
//   bankb, addrb   read slot; holds its value while reb is low
//   rd_valid       read data valid this cycle
//   rd_bank, rd_op read slot tag aligned to the read data
//   rd_last        final slot of the frame, aligned to rd_valid
//   wea            write-back strobe
//   banka, addra   write-back slot; holds its value while wea is low
//   busy           frame in progress (ISSUE, DRAIN, DONE)
//   frame_done     one-cycle pulse after the last write-back
//   overrun        sticky flag: a tick arrived while busy
//
// Build option
//   OPL3_SLOT_OVERRUN_CHECK_EN: when defined, overrun detection is built.
//   When it is undefined, overrun is tied low. Sequencing is the same in
//   both builds.

module opl3_slot_sequencer #(
  parameter int NUM_BANKS  = 2,
  parameter int NUM_OPS    = 18,
  parameter int READ_DELAY = 1,
  parameter int PROC_DELAY = 3,
  localparam int BANK_WIDTH = $clog2(NUM_BANKS),
  localparam int OP_WIDTH   = $clog2(NUM_OPS)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  sample_clk_en,
  output logic                  reb,
  output logic [BANK_WIDTH-1:0] bankb,
  output logic [OP_WIDTH-1:0]   addrb,
  output logic                  rd_valid,
  output logic [BANK_WIDTH-1:0] rd_bank,
  output logic [OP_WIDTH-1:0]   rd_op,
  output logic                  rd_last,
  output logic                  wea,
  output logic [BANK_WIDTH-1:0] banka,
  output logic [OP_WIDTH-1:0]   addra,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  overrun
);

  // state | meaning
  // IDLE  | waiting for sample_clk_en
  // ISSUE | one read per cycle, walking all slots
  // DRAIN | reads done, waiting for the last write-back
  // DONE  | frame_done pulse, then back to IDLE
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  logic [BANK_WIDTH-1:0] bank_cnt;
  logic [OP_WIDTH-1:0]   op_cnt;
  logic                  last_slot;
  logic                  issue_last;
  logic                  wb_last;

  assign last_slot  = (bank_cnt == BANK_WIDTH'(NUM_BANKS - 1)) &&
                      (op_cnt == OP_WIDTH'(NUM_OPS - 1));
  assign issue_last = reb && last_slot;

  assign bankb = bank_cnt;
  assign addrb = op_cnt;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    reb        = 1'b0;
    busy       = 1'b1;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (sample_clk_en) begin
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        reb = 1'b1;
        if (last_slot) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        // The last write-back carries the frame's last tag. Leaving on that
        // strobe puts frame_done exactly one cycle after it.
        if (wea && wb_last) begin
          state_next = DONE;
        end
      end
      DONE: begin
        frame_done = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Slot counters. The counters stop on the last slot instead of wrapping,
  // so bankb/addrb keep showing the last slot read until the next frame.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bank_cnt <= '0;
      op_cnt   <= '0;
    end else if (state == IDLE && sample_clk_en) begin
      bank_cnt <= '0;
      op_cnt   <= '0;
    end else if (state == ISSUE && !last_slot) begin
      if (op_cnt == OP_WIDTH'(NUM_OPS - 1)) begin
        op_cnt   <= '0;
        bank_cnt <= bank_cnt + BANK_WIDTH'(1);
      end else begin
        op_cnt <= op_cnt + OP_WIDTH'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read tag pipeline. Valid and last shift every cycle. The slot tag is
  // captured only alongside a valid, so the tag holds during bubbles.
  // ---------------------------------------------------------------------------
  generate
    if (READ_DELAY == 0) begin : g_rd_comb
      assign rd_valid = reb;
      assign rd_bank  = bankb;
      assign rd_op    = addrb;
      assign rd_last  = issue_last;
    end else begin : g_rd_pipe
      logic                  v_q    [READ_DELAY];
      logic                  last_q [READ_DELAY];
      logic [BANK_WIDTH-1:0] bank_q [READ_DELAY];
      logic [OP_WIDTH-1:0]   op_q   [READ_DELAY];

      always_ff @(posedge clk) begin
        if (!reset_n) begin
          for (int i = 0; i < READ_DELAY; i++) begin
            v_q[i]    <= 1'b0;
            last_q[i] <= 1'b0;
            bank_q[i] <= '0;
            op_q[i]   <= '0;
          end
        end else begin
          v_q[0]    <= reb;
          last_q[0] <= issue_last;
          if (reb) begin
            bank_q[0] <= bankb;
            op_q[0]   <= addrb;
          end
          for (int i = 1; i < READ_DELAY; i++) begin
            v_q[i]    <= v_q[i-1];
            last_q[i] <= last_q[i-1];
            if (v_q[i-1]) begin
              bank_q[i] <= bank_q[i-1];
              op_q[i]   <= op_q[i-1];
            end
          end
        end
      end

      assign rd_valid = v_q[READ_DELAY-1];
      assign rd_last  = last_q[READ_DELAY-1];
      assign rd_bank  = bank_q[READ_DELAY-1];
      assign rd_op    = op_q[READ_DELAY-1];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Write-back pipeline: the read tag delayed by PROC_DELAY (always >= 1).
  // The last flag goes along with the tag so that DRAIN knows when the
  // frame is complete.
  // ---------------------------------------------------------------------------
  logic                  wv_q    [PROC_DELAY];
  logic                  wlast_q [PROC_DELAY];
  logic [BANK_WIDTH-1:0] wbank_q [PROC_DELAY];
  logic [OP_WIDTH-1:0]   wop_q   [PROC_DELAY];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < PROC_DELAY; i++) begin
        wv_q[i]    <= 1'b0;
        wlast_q[i] <= 1'b0;
        wbank_q[i] <= '0;
        wop_q[i]   <= '0;
      end
    end else begin
      wv_q[0]    <= rd_valid;
      wlast_q[0] <= rd_last;
      if (rd_valid) begin
        wbank_q[0] <= rd_bank;
        wop_q[0]   <= rd_op;
      end
      for (int i = 1; i < PROC_DELAY; i++) begin
        wv_q[i]    <= wv_q[i-1];
        wlast_q[i] <= wlast_q[i-1];
        if (wv_q[i-1]) begin
          wbank_q[i] <= wbank_q[i-1];
          wop_q[i]   <= wop_q[i-1];
        end
      end
    end
  end

  assign wea     = wv_q[PROC_DELAY-1];
  assign wb_last = wlast_q[PROC_DELAY-1];
  assign banka   = wbank_q[PROC_DELAY-1];
  assign addra   = wop_q[PROC_DELAY-1];

  // ---------------------------------------------------------------------------
  // Overrun flag. It is set by a tick in any busy cycle, DONE included,
  // and it is cleared only by reset.
  // ---------------------------------------------------------------------------
`ifdef OPL3_SLOT_OVERRUN_CHECK_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      overrun <= 1'b0;
    end else if (sample_clk_en && busy) begin
      overrun <= 1'b1;
    end
  end
`else
  assign overrun = 1'b0;
`endif

endmodule
